float2int_seq: RTL and testbench

FLOAT2INT_SEQ -- requirements
Module: float2int_seq

---
 rtl/float2int_pkg.sv | 27 ++
 rtl/float2int_seq.sv | 76 +++++++
 tb/tb_float2int_seq.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/float2int_pkg.sv
// Float-code format shared by the float2int decoder and the int2float encoder.
// Holds field widths, the decoder state encoding and the reference encoder function.
package float2int_pkg;

   localparam int MW        = 4;
   localparam int EW        = 3;
   localparam int IW        = 11;
   localparam int MAX_SHIFT = 6;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} f2i_state_t;

   // Integer -> {E,M}. The MSB above the mantissa field becomes the implicit one.
   function automatic logic [EW+MW-1:0] i2f_encode(input logic [IW-1:0] v);
      logic [EW-1:0] e;
      logic [MW-1:0] m;
      e = '0;
      m = v[MW-1:0];
      for (int p = MW; p < IW; p++) begin
         if (v[p]) begin
            e = EW'(p - MW + 1);
            m = MW'(v >> (p - MW));
         end
      end
      return {e, m};
   endfunction

endpackage

// File: rtl/float2int_seq.sv
// Sequential float-code to unsigned integer converter: loads {hidden, M}
// and left-shifts once per cycle until the exponent count is used up.
module float2int_seq
   import float2int_pkg::*;
#(
   parameter int IW = float2int_pkg::IW,
   parameter int MW = float2int_pkg::MW,
   parameter int EW = float2int_pkg::EW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [MW-1:0] M,
   input  logic [EW-1:0] E,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [IW-1:0] B
);

   f2i_state_t    state;
   logic [EW-1:0] cnt;
   logic [IW-1:0] wreg;
   logic [IW-1:0] ld_val;
   logic [EW-1:0] ld_cnt;

   always_comb begin
      ld_val = IW'({(E != '0), M});
      ld_cnt = (E == '0) ? '0 : E - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         wreg      <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         B         <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               wreg     <= ld_val;
               cnt      <= ld_cnt;
               in_ready <= 1'b0;
               if (ld_cnt == '0) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  B         <= ld_val;
               end else begin
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               wreg <= wreg << 1;
               cnt  <= cnt - 1'b1;
               // Last shift lands directly in DONE so latency is max(E-1,0)+1.
               if (cnt == EW'(1)) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  B         <= wreg << 1;
               end
            end
            DONE: if (out_ready) begin
               state     <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               B         <= '0;
               wreg      <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_float2int_seq.sv
// Scoreboard bench for float2int_seq: directed latency/backpressure/reset cases
// plus a back-to-back sweep of all 128 codes under random out_ready.
module tb_float2int_seq;
   import float2int_pkg::*;

   typedef struct {
      logic [10:0] b;
      logic [6:0]  code;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  M;
   logic [2:0]  E;
   logic        out_valid;
   logic        out_ready;
   logic [10:0] B;

   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   int   acc   = 0;
   bit   rnd_rdy = 1'b0;
   bit   mon_en  = 1'b0;
   exp_t exp_q[$];

   float2int_seq dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .M(M), .E(E), .out_valid(out_valid), .out_ready(out_ready), .B(B)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #2;
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [10:0] model(input int e, input int m);
      if (e == 0) return 11'(m);
      return 11'((16 + m) << (e - 1));
   endfunction

   // Scoreboard: pop on every handshake; B must read 0 whenever not valid.
   always @(negedge clk) begin
      if (mon_en) begin
         if (!out_valid) chk("b_idle_zero", B, 0);
         else if (out_ready) begin
            if (exp_q.size() == 0) chk("spurious_out", out_valid, 0);
            else begin
               exp_t x;
               x = exp_q.pop_front();
               chk($sformatf("B_e%0d_m%0d", x.code[6:4], x.code[3:0]), B, x.b);
               chk("roundtrip", i2f_encode(B), x.code);
            end
         end
      end
   end

   // Call at posedge+2; returns at posedge+2 right after the accept edge.
   task automatic send(input int e, input int m);
      exp_t x;
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1;
      E = 3'(e);
      M = 4'(m);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("accept_timeout", in_ready, 1);
      acc    = cyc;
      x.b    = model(e, m);
      x.code = 7'({e[2:0], m[3:0]});
      if (ok) exp_q.push_back(x);
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      E = 3'($urandom);
      M = 4'($urandom);
   endtask

   task automatic wait_valid(input string tag, input int exp_lat);
      int lat;
      lat = -1;
      for (int i = 0; i < 20; i++) begin
         if (i > 0 || 1'b1) @(negedge clk);
         if (out_valid) begin
            lat = cyc - acc;
            break;
         end
      end
      chk(tag, lat, exp_lat);
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; E = '0; M = '0;
      repeat (3) tick();
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_B", B, 0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("in_ready_after_rst", in_ready, 1);
      mon_en = 1'b1;
      tick();

      out_ready = 1'b1;
      send(0, 9);  wait_valid("lat_e0_m9", 1);  tick();
      send(1, 0);  wait_valid("lat_e1_m0", 1);  tick();
      send(7, 15); wait_valid("lat_e7_m15", 7); tick();

      // Backpressure: hold out_ready low, offer a stray code that must be ignored.
      out_ready = 1'b0;
      send(4, 5);
      wait_valid("lat_e4_m5", 4);
      tick();
      in_valid = 1'b1; E = 3'd0; M = 4'd1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_B", B, 168);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      tick();
      @(negedge clk);
      chk("bp_idle_in_ready", in_ready, 1);
      chk("bp_idle_out_valid", out_valid, 0);
      tick();

      // Reset in the middle of an E=6 shift sequence.
      send(6, 3);
      tick();
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_B", B, 0);
      exp_q.delete();
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready", in_ready, 1);
      begin
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
         end
         chk("midrst_no_output", seen, 0);
      end
      tick();

      // Sweep every code back to back under random backpressure.
      rnd_rdy = 1'b1;
      for (int e = 0; e < 8; e++)
         for (int m = 0; m < 16; m++)
            send(e, m);
      for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
      chk("drain", exp_q.size(), 0);
      rnd_rdy = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
